// File: rtl/io_pkg.sv
// Shared constants and types for the cpu console I/O bridge.
//   WORD_W        : data word width, matches the cpu in/out data buses
//   IO_FIFO_DEPTH : entries per direction FIFO (power of two, >= 2)
//   io_word_t     : one console data word
package io_pkg;
  localparam int WORD_W        = 64;
  localparam int IO_FIFO_DEPTH = 16;

  typedef logic [WORD_W-1:0] io_word_t;
endpackage

// File: rtl/cpu_io_port_if.sv
// Bundle of all cpu-side and host-side signals of cpu_io_port.
//   slave  : the bridge itself
//   master : the environment driving the cpu strobes and the host link
//
// Handshake semantics (host link): a word moves on host_tx_* when
// host_tx_valid && host_tx_ready are both high at a rising clock edge, and
// on host_rx_* when host_rx_valid && host_rx_ready are both high at a
// rising edge. valid never depends on ready on the same side. The cpu
// strobes have no handshake: every high cycle is one transfer.
interface cpu_io_port_if
  import io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = IO_FIFO_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cpu_in_signal;
  logic [WIDTH-1:0] cpu_in_data;
  logic             cpu_out_signal;
  logic [WIDTH-1:0] cpu_out_data;
  logic             host_tx_valid;
  logic [WIDTH-1:0] host_tx_data;
  logic             host_tx_ready;
  logic             host_rx_valid;
  logic [WIDTH-1:0] host_rx_data;
  logic             host_rx_ready;
  logic [CW-1:0]    in_count;
  logic [CW-1:0]    out_count;
  logic             overflow;
  logic             underflow;
  logic             clear_errors;

  modport slave (
    input  cpu_in_signal, cpu_out_signal, cpu_out_data,
    input  host_tx_ready, host_rx_valid, host_rx_data, clear_errors,
    output cpu_in_data, host_tx_valid, host_tx_data, host_rx_ready,
    output in_count, out_count, overflow, underflow
  );

  modport master (
    output cpu_in_signal, cpu_out_signal, cpu_out_data,
    output host_tx_ready, host_rx_valid, host_rx_data, clear_errors,
    input  cpu_in_data, host_tx_valid, host_tx_data, host_rx_ready,
    input  in_count, out_count, overflow, underflow
  );
endinterface

// File: rtl/io_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push/wdata : write request and data
//   pop        : read request; rdata is the current head (combinational)
//   full/empty : status derived from pointers
//   count      : registered occupancy, updated on the same edge as pointers
// A push while full is accepted when a pop happens in the same cycle.
// A pop on empty does nothing; a push into empty shows at the head next cycle.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = IO_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra MSB on each pointer is the wrap bit: equal indices with differing
  // wrap bits means full, fully equal pointers means empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/cpu_io_port.sv
// Buffered console I/O bridge between the cpu in/out port pins and a host.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, discards queued words both ways
//   bus   : cpu_io_port_if.slave carrying
//           cpu_in_signal/cpu_in_data   cpu read strobe and input FIFO head
//           cpu_out_signal/cpu_out_data cpu write strobe and word
//           host_tx_*                   output FIFO drain to host (valid/ready)
//           host_rx_*                   host words into input FIFO (valid/ready)
//           in_count/out_count          FIFO occupancies
//           overflow/underflow          sticky error flags, clear_errors clears
module cpu_io_port
  import io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = IO_FIFO_DEPTH
) (
  input logic           clk,
  input logic           reset,
  cpu_io_port_if.slave  bus
);
  logic [WIDTH-1:0] in_rdata;
  logic             in_full;
  logic             in_empty;
  logic             out_full;
  logic             out_empty;
  logic             tx_pop;
  logic             rx_push;
  logic             overflow_now;
  logic             underflow_now;

  assign tx_pop  = bus.host_tx_valid && bus.host_tx_ready;
  assign rx_push = bus.host_rx_valid && bus.host_rx_ready;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cpu_out_signal),
    .pop   (tx_pop),
    .wdata (bus.cpu_out_data),
    .rdata (bus.host_tx_data),
    .full  (out_full),
    .empty (out_empty),
    .count (bus.out_count)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (bus.cpu_in_signal),
    .wdata (bus.host_rx_data),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .count (bus.in_count)
  );

  assign bus.host_tx_valid = !out_empty;
  assign bus.host_rx_ready = !in_full;
  // Stale storage must never leak to the cpu, so an empty FIFO reads as 0.
  assign bus.cpu_in_data   = in_empty ? '0 : in_rdata;

  // A cpu write is only lost when the FIFO is full and nothing drains now.
  assign overflow_now  = bus.cpu_out_signal && out_full && !tx_pop;
  assign underflow_now = bus.cpu_in_signal && in_empty;

  // A new error in the same cycle as clear_errors takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (overflow_now)          bus.overflow <= 1'b1;
      else if (bus.clear_errors) bus.overflow <= 1'b0;
      if (underflow_now)         bus.underflow <= 1'b1;
      else if (bus.clear_errors) bus.underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_io_port.sv
// Self-checking bench for cpu_io_port: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cpu_io_port;
  localparam int W = 64;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_io_port_if #(.WIDTH(W), .DEPTH(D)) bus ();

  cpu_io_port #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  logic [W-1:0] out_q[$];
  logic [W-1:0] in_q[$];
  logic [W-1:0] rx_log[$];   // words the host actually accepted
  logic         m_of;
  logic         m_uf;

  int tests  = 0;
  int errors = 0;

  // Observations taken at the sample point of the last step
  logic [W-1:0] obs_in_data, obs_tx_data;
  logic         obs_tx_valid, obs_of, obs_uf;
  int           obs_in_count, obs_out_count;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    out_q.delete();
    in_q.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_check();
    chk("tx_valid", W'(bus.host_tx_valid), W'(out_q.size() != 0));
    if (out_q.size() != 0) chk("tx_data", bus.host_tx_data, out_q[0]);
    chk("rx_ready", W'(bus.host_rx_ready), W'(in_q.size() < D));
    chk("in_data", bus.cpu_in_data, (in_q.size() != 0) ? in_q[0] : '0);
    chk("out_count", W'(bus.out_count), W'(out_q.size()));
    chk("in_count", W'(bus.in_count), W'(in_q.size()));
    chk("overflow", W'(bus.overflow), W'(m_of));
    chk("underflow", W'(bus.underflow), W'(m_uf));
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, advance the model.
  task automatic step(input logic isig, input logic osig, input logic [W-1:0] odata,
                      input logic txr, input logic rxv, input logic [W-1:0] rxd,
                      input logic clr);
    logic popo, pusho, popi, pushi, of, uf;
    @(negedge clk);
    bus.cpu_in_signal  = isig;
    bus.cpu_out_signal = osig;
    bus.cpu_out_data   = odata;
    bus.host_tx_ready  = txr;
    bus.host_rx_valid  = rxv;
    bus.host_rx_data   = rxd;
    bus.clear_errors   = clr;
    #1;
    obs_in_data   = bus.cpu_in_data;
    obs_tx_data   = bus.host_tx_data;
    obs_tx_valid  = bus.host_tx_valid;
    obs_of        = bus.overflow;
    obs_uf        = bus.underflow;
    obs_in_count  = int'(bus.in_count);
    obs_out_count = int'(bus.out_count);
    model_check();
    popo  = (out_q.size() != 0) && txr;
    pusho = osig && ((out_q.size() < D) || popo);
    of    = osig && !pusho;
    popi  = isig && (in_q.size() != 0);
    uf    = isig && (in_q.size() == 0);
    pushi = rxv && (in_q.size() < D);
    if (popo)  rx_log.push_back(out_q.pop_front());
    if (pusho) out_q.push_back(odata);
    if (popi)  void'(in_q.pop_front());
    if (pushi) in_q.push_back(rxd);
    m_of = of ? 1'b1 : (clr ? 1'b0 : m_of);
    m_uf = uf ? 1'b1 : (clr ? 1'b0 : m_uf);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_in_signal = 1'b0; bus.cpu_out_signal = 1'b0; bus.cpu_out_data = '0;
    bus.host_tx_ready = 1'b0; bus.host_rx_valid = 1'b0; bus.host_rx_data = '0;
    bus.clear_errors  = 1'b0;
    #1;
    model_clear();
    model_check();
    @(negedge clk);
    #1;
    model_check();
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int dead_seen;
    model_clear();
    do_reset();

    // 1: reset with three words queued on each side
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, W'(64'h100 + i), 1'b0, 1'b1, W'(64'h200 + i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);   // empty-side activity: none, sets nothing
    do_reset();
    chk("t1_out_count", W'(bus.out_count), 0);
    chk("t1_in_count", W'(bus.in_count), 0);
    chk("t1_tx_valid", W'(bus.host_tx_valid), 0);
    chk("t1_rx_ready", W'(bus.host_rx_ready), 1);
    chk("t1_flags", W'({bus.overflow, bus.underflow}), 0);

    // 2: three writes held back, then drained at one per cycle
    rx_log.delete();
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 64'hB, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 64'hC, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t2_data0", obs_tx_data, 64'hA);
    chk("t2_cnt0", W'(obs_out_count), 3);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t2_data1", obs_tx_data, 64'hB);
    chk("t2_cnt1", W'(obs_out_count), 2);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t2_data2", obs_tx_data, 64'hC);
    chk("t2_cnt2", W'(obs_out_count), 1);
    idle();
    chk("t2_cnt3", W'(obs_out_count), 0);
    chk("t2_log", W'(rx_log.size()), 3);

    // 3: overflow on a full output FIFO, then accepted push with drain
    rx_log.delete();
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'(64'h300 + i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b0, '0, 1'b0);
    idle();
    chk("t3_cnt_full", W'(obs_out_count), 16);
    chk("t3_overflow", W'(obs_of), 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 64'hBEEF, 1'b1, 1'b0, '0, 1'b0);
    idle();
    chk("t3_cnt_kept", W'(obs_out_count), 16);
    chk("t3_no_overflow", W'(obs_of), 0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    dead_seen = 0;
    foreach (rx_log[i]) if (rx_log[i] == 64'hDEAD) dead_seen++;
    chk("t3_no_dead", W'(dead_seen), 0);
    chk("t3_first", rx_log[0], 64'h300);
    chk("t3_last", rx_log[rx_log.size()-1], 64'hBEEF);

    // 4: zero-latency cpu read
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h1234, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("t4_in_data", obs_in_data, 64'h1234);
    chk("t4_cnt1", W'(obs_in_count), 1);
    idle();
    chk("t4_cnt0", W'(obs_in_count), 0);

    // 5: read on empty while host pushes
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 64'h55, 1'b0);
    chk("t5_in_data0", obs_in_data, 0);
    idle();
    chk("t5_underflow", W'(obs_uf), 1);
    chk("t5_cnt", W'(obs_in_count), 1);
    chk("t5_head", obs_in_data, 64'h55);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // 6: 40 words streamed through the input FIFO, then flag clear
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, W'(64'd1000), 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, W'(64'd1000 + i), 1'b0);
      chk("t6_order", obs_in_data, W'(64'd1000 + i - 1));
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_last", obs_in_data, W'(64'd1039));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("t6_uf_before", W'(obs_uf), 1);
    idle();
    chk("t6_flags_clr", W'({obs_of, obs_uf}), 0);

    // Randomized traffic against the model, with a mid-stream reset
    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, {$urandom, $urandom},
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, {$urandom, $urandom},
           $urandom_range(0, 15) == 0);
    end
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 31) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
